// File: rtl/plic_target_ctrl.sv
// plic_target_ctrl: per-target PLIC request/claim/complete controller
module plic_target_ctrl #(
  parameter int SOURCES = 16,
  parameter int PRIORITIES = 7,
  parameter int SOURCES_BITS = $clog2(SOURCES + 1),
  parameter int PRIORITY_BITS = $clog2(PRIORITIES)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PRIORITY_BITS-1:0] priority_i,
  input  logic [SOURCES_BITS-1:0]  id_i,
  input  logic [PRIORITY_BITS-1:0] threshold_i,
  input  logic                     claim_i,
  input  logic                     complete_i,
  input  logic [SOURCES_BITS-1:0]  complete_id_i,
  output logic                     ireq_o,
  output logic [SOURCES_BITS-1:0]  id_o,
  output logic                     claim_o,
  output logic [SOURCES_BITS-1:0]  claim_id_o,
  output logic                     complete_o,
  output logic [SOURCES_BITS-1:0]  complete_id_o,
  output logic                     busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, CLAIMED} state_t;
  state_t state_q, state_d;
  logic [PRIORITY_BITS-1:0] prio_r;
  logic [SOURCES_BITS-1:0] id_r;
  logic req, claim_ok, done;
  assign req = prio_r > threshold_i;
  // next state plus claim acceptance and matching completion; claim_id_o holds the outstanding ID
  always_comb begin
    state_d = state_q;
    claim_ok = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: state_d = (req && !claim_i) ? REQ : IDLE;
      REQ: begin
        claim_ok = claim_i && req;
        state_d = claim_ok ? CLAIMED : (req && !claim_i) ? REQ : IDLE;
      end
      CLAIMED: begin
        done = complete_i && (complete_id_i == claim_id_o);
        state_d = done ? IDLE : CLAIMED;
      end
      default: state_d = IDLE;
    endcase
  end
  // pipeline stage, state register and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_r <= '0;
      id_r <= '0;
      ireq_o <= 1'b0;
      busy_o <= 1'b0;
      id_o <= '0;
      claim_o <= 1'b0;
      claim_id_o <= '0;
      complete_o <= 1'b0;
      complete_id_o <= '0;
    end else begin
      state_q <= state_d;
      prio_r <= priority_i;
      id_r <= id_i;
      ireq_o <= state_d == REQ;
      busy_o <= state_d == CLAIMED;
      claim_o <= claim_ok;
      complete_o <= done;
      if (claim_i) id_o <= claim_ok ? id_r : '0;
      if (claim_ok) claim_id_o <= id_r;
      if (done) complete_id_o <= complete_id_i;
    end
  end
endmodule

// File: tb/tb_plic_target_ctrl.sv
// tb_plic_target_ctrl: directed and random checks against a behavioural model
module tb_plic_target_ctrl;
  localparam int SB = 5;
  localparam int PB = 3;
  logic clk = 0, rst_n = 0;
  logic [PB-1:0] priority_i = 0, threshold_i = 0;
  logic [SB-1:0] id_i = 0, complete_id_i = 0;
  logic claim_i = 0, complete_i = 0;
  logic ireq_o, claim_o, complete_o, busy_o;
  logic [SB-1:0] id_o, claim_id_o, complete_id_o;
  int n_cmp = 0, n_bad = 0;
  int m_prio, m_idr, e_id, e_cid, e_comp_id;
  bit m_ireq, m_busy, e_claim, e_comp;

  plic_target_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .priority_i(priority_i), .id_i(id_i),
    .threshold_i(threshold_i), .claim_i(claim_i), .complete_i(complete_i),
    .complete_id_i(complete_id_i), .ireq_o(ireq_o), .id_o(id_o), .claim_o(claim_o),
    .claim_id_o(claim_id_o), .complete_o(complete_o), .complete_id_o(complete_id_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_idr = 0; m_ireq = 0; m_busy = 0;
    e_id = 0; e_cid = 0; e_comp_id = 0; e_claim = 0; e_comp = 0;
  endtask

  task automatic check_all();
    chk("ireq", ireq_o, m_ireq);
    chk("busy", busy_o, m_busy);
    chk("id", id_o, e_id);
    chk("claim", claim_o, e_claim);
    chk("claim_id", claim_id_o, e_cid);
    chk("complete", complete_o, e_comp);
    chk("complete_id", complete_id_o, e_comp_id);
  endtask

  // one clock: the target requests whenever idle with a pending priority above
  // threshold; a claim is granted only while requesting and still above threshold
  task automatic step();
    bit req, grant, fin;
    @(posedge clk);
    req = m_prio > int'(threshold_i);
    grant = m_ireq && claim_i && req;
    fin = m_busy && complete_i && int'(complete_id_i) == e_cid;
    if (claim_i) e_id = grant ? m_idr : 0;
    if (grant) e_cid = m_idr;
    if (fin) e_comp_id = complete_id_i;
    e_claim = grant;
    e_comp = fin;
    m_ireq = !m_busy && req && !claim_i;
    m_busy = m_busy ? !fin : grant;
    m_prio = priority_i;
    m_idr = id_i;
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst_n = 1;
    #2;
    priority_i = 3; id_i = 5; threshold_i = 1;
    step();
    chk("lat_ireq_c1", ireq_o, 0);
    step();
    chk("lat_ireq_c2", ireq_o, 1);
    step();
    claim_i = 1;
    step();
    claim_i = 0;
    chk("c_id", id_o, 5); chk("c_pulse", claim_o, 1); chk("c_cid", claim_id_o, 5);
    chk("c_busy", busy_o, 1); chk("c_ireq", ireq_o, 0);
    complete_i = 1; complete_id_i = 4;
    step();
    chk("bad_cmp", complete_o, 0); chk("bad_busy", busy_o, 1);
    complete_id_i = 5;
    step();
    complete_i = 0;
    chk("cmp", complete_o, 1); chk("cmp_id", complete_id_o, 5); chk("cmp_busy", busy_o, 0);
    step();
    chk("cmp_pulse_w", complete_o, 0);
    claim_i = 1;
    step();
    chk("reclaim", busy_o, 1);
    complete_i = 1; complete_id_i = 5;
    step();
    claim_i = 0; complete_i = 0;
    chk("sim_id", id_o, 0); chk("sim_cmp", complete_o, 1);
    chk("sim_claim", claim_o, 0); chk("sim_busy", busy_o, 0);
    priority_i = 2; id_i = 3; threshold_i = 2;
    repeat (3) step();
    chk("thr_eq_ireq", ireq_o, 0);
    claim_i = 1;
    step();
    claim_i = 0;
    chk("idle_claim_id", id_o, 0); chk("idle_claim_p", claim_o, 0);
    threshold_i = 1;
    step();
    chk("thr_low_ireq", ireq_o, 1);
    threshold_i = 6; claim_i = 1;
    step();
    claim_i = 0;
    chk("mask_ireq", ireq_o, 0); chk("mask_id", id_o, 0); chk("mask_claim", claim_o, 0);
    threshold_i = 1;
    step();
    claim_i = 1;
    step();
    claim_i = 0;
    chk("pre_rst_busy", busy_o, 1);
    step();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    complete_i = 1; complete_id_i = 3;
    #10 rst_n = 1;
    repeat (4) step();
    complete_i = 0;
    for (int i = 0; i < 400; i++) begin
      priority_i = PB'($urandom_range(0, 6));
      id_i = SB'($urandom_range(0, 16));
      if ($urandom_range(0, 9) == 0) threshold_i = PB'($urandom_range(0, 6));
      claim_i = $urandom_range(0, 3) == 0;
      complete_i = $urandom_range(0, 3) == 0;
      complete_id_i = $urandom_range(0, 1) ? SB'(e_cid) : SB'($urandom_range(0, 16));
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
